// File: rtl/temp_ctrl_pkg.sv
// Shared constants for the Temp_Controller display path:
// converter state encoding and BCD digit adjust values.
package temp_ctrl_pkg;

    typedef logic [0:0] state_t;

    localparam state_t ST_IDLE  = 1'b0;
    localparam state_t ST_SHIFT = 1'b1;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [DIGIT_W-1:0] BCD_ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble digit correction: add 3 when the digit is 5 or more.
// The largest result is 12, so the 4-bit sum never wraps.
module bcd_digit_adj
    import temp_ctrl_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [DIGIT_W-1:0] o_digit
);

    logic w_ge;

    assign w_ge    = (i_digit >= BCD_ADJ_THRESH);
    assign o_digit = w_ge ? (i_digit + BCD_ADJ_ADD) : i_digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary to packed-BCD converter, one input bit per clock.
// Digits lost off the top of the scratch register raise overflow.
module bin_to_bcd_seq
    import temp_ctrl_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic                      start,
    input  logic [WIDTH-1:0]          bin,
    output logic                      busy,
    output logic                      done,
    output logic [DIGIT_W*DIGITS-1:0] bcd,
    output logic                      overflow
);

    localparam int SW = DIGIT_W * DIGITS;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shreg;
    logic [SW-1:0]    r_scratch;
    logic             r_ovf_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_done;
    logic [SW-1:0]    r_bcd;
    logic             r_ovf;

    logic [SW-1:0]    w_adj;
    logic [SW-1:0]    w_scratch_nxt;
    logic             w_out_bit;
    logic             w_last;
    logic             w_load;
    logic             w_shift;
    logic             w_finish;

    for (genvar k = 0; k < DIGITS; k++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_digit (r_scratch[DIGIT_W*k +: DIGIT_W]),
            .o_digit (w_adj[DIGIT_W*k +: DIGIT_W])
        );
    end

    // Adjusted digits shift left; the top bit leaves the register.
    assign w_out_bit     = w_adj[SW-1];
    assign w_scratch_nxt = {w_adj[SW-2:0], r_shreg[WIDTH-1]};
    assign w_last        = (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_load   = 1'b0;
        w_shift  = 1'b0;
        w_finish = 1'b0;
        busy     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_load = start;
            end
            ST_SHIFT: begin
                w_shift  = 1'b1;
                w_finish = w_last;
                busy     = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_shreg   <= '0;
            r_scratch <= '0;
            r_ovf_acc <= 1'b0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_bcd     <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_load) begin
                r_shreg   <= bin;
                r_scratch <= '0;
                r_ovf_acc <= 1'b0;
                r_cnt     <= CW'(WIDTH - 1);
            end
            if (w_shift) begin
                r_shreg   <= r_shreg << 1;
                r_scratch <= w_scratch_nxt;
                r_ovf_acc <= r_ovf_acc | w_out_bit;
                r_cnt     <= r_cnt - 1'b1;
            end
            if (w_finish) begin
                r_bcd <= w_scratch_nxt;
                r_ovf <= r_ovf_acc | w_out_bit;
            end
        end
    end

    assign done     = r_done;
    assign bcd      = r_bcd;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: a 3-digit and a 2-digit instance
// share clock and reset; each task checks one behaviour.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [7:0]  bin;
    logic        busy;
    logic        done;
    logic [11:0] bcd;
    logic        ovf;

    logic        start2;
    logic [7:0]  bin2;
    logic        busy2;
    logic        done2;
    logic [7:0]  bcd2;
    logic        ovf2;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) u_dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd),
        .overflow (ovf)
    );

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) u_dut2 (
        .clk      (clk),
        .clr      (clr),
        .start    (start2),
        .bin      (bin2),
        .busy     (busy2),
        .done     (done2),
        .bcd      (bcd2),
        .overflow (ovf2)
    );

    // Start one conversion on the 3-digit unit; lat counts edges to done.
    task automatic run1(input logic [7:0] v, output logic [11:0] r,
                        output logic o, output int lat, output int bc);
        @(negedge clk);
        bin   = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        bc  = 0;
        while (!done && lat < 20) begin
            if (busy) bc++;
            @(negedge clk);
            lat++;
        end
        r = bcd;
        o = ovf;
    endtask

    task automatic run2(input logic [7:0] v, output logic [7:0] r,
                        output logic o, output int lat);
        @(negedge clk);
        bin2   = v;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        lat = 0;
        while (!done2 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        r = bcd2;
        o = ovf2;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        start = 1'b0; bin = 8'd0;
        start2 = 1'b0; bin2 = 8'd0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, bcd, ovf} !== 15'd0) begin
            failures++;
            $display("FAIL reset3 got=%h want=0", {busy, done, bcd, ovf});
        end
        checks++;
        if ({busy2, done2, bcd2, ovf2} !== 11'd0) begin
            failures++;
            $display("FAIL reset2 got=%h want=0", {busy2, done2, bcd2, ovf2});
        end
        clr = 1'b0;
    endtask

    task automatic test_zero();
        logic [11:0] r;
        logic o;
        int lat, bc;
        run1(8'd0, r, o, lat, bc);
        checks++;
        if (lat !== 8) begin
            failures++;
            $display("FAIL zero_latency got=%0d want=8", lat);
        end
        checks++;
        if (bc !== 8) begin
            failures++;
            $display("FAIL zero_busy_cycles got=%0d want=8", bc);
        end
        checks++;
        if (r !== 12'h000 || o !== 1'b0) begin
            failures++;
            $display("FAIL zero_result got=%h/%b want=000/0", r, o);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL done_one_cycle got=%b/%b want=0/0", done, busy);
        end
    endtask

    task automatic test_values();
        logic [7:0]  vin [4] = '{8'd255, 8'd9, 8'd58, 8'd137};
        logic [11:0] vexp [4] = '{12'h255, 12'h009, 12'h058, 12'h137};
        logic [11:0] r;
        logic o;
        int lat, bc;
        for (int i = 0; i < 4; i++) begin
            run1(vin[i], r, o, lat, bc);
            checks++;
            if (r !== vexp[i] || o !== 1'b0 || lat !== 8) begin
                failures++;
                $display("FAIL value_%0d got=%h/%b lat=%0d want=%h/0 lat=8",
                         vin[i], r, o, lat, vexp[i]);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int n;
        @(negedge clk);
        bin = 8'd55; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        bin = 8'd77; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (bcd !== 12'h137 || busy !== 1'b1) begin
            failures++;
            $display("FAIL hold_prior got=%h busy=%b want=137 busy=1", bcd, busy);
        end
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 1'b1 || bcd !== 12'h055) begin
            failures++;
            $display("FAIL ignore_start got=%h done=%b want=055 done=1", bcd, done);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL no_queue got busy=%b want=0", busy);
        end
    endtask

    task automatic test_back_to_back();
        int n, t1, t2;
        @(negedge clk);
        bin = 8'd42; start = 1'b1;
        @(negedge clk);
        bin = 8'd199;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        t1 = cyc;
        checks++;
        if (done !== 1'b1 || bcd !== 12'h042) begin
            failures++;
            $display("FAIL b2b_first got=%h done=%b want=042 done=1", bcd, done);
        end
        @(negedge clk);
        bin = 8'd7;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        t2 = cyc;
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || bcd !== 12'h199) begin
            failures++;
            $display("FAIL b2b_second got=%h done=%b want=199 done=1", bcd, done);
        end
        checks++;
        if (t2 - t1 !== 9) begin
            failures++;
            $display("FAIL b2b_spacing got=%0d want=9", t2 - t1);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_stop got busy=%b want=0", busy);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] r;
        logic o;
        int lat;
        run2(8'd100, r, o, lat);
        checks++;
        if (r !== 8'h00 || o !== 1'b1 || lat !== 8) begin
            failures++;
            $display("FAIL ovf_100 got=%h/%b lat=%0d want=00/1 lat=8", r, o, lat);
        end
        run2(8'd99, r, o, lat);
        checks++;
        if (r !== 8'h99 || o !== 1'b0) begin
            failures++;
            $display("FAIL ovf_99 got=%h/%b want=99/0", r, o);
        end
        run2(8'd231, r, o, lat);
        checks++;
        if (r !== 8'h31 || o !== 1'b1) begin
            failures++;
            $display("FAIL ovf_231 got=%h/%b want=31/1", r, o);
        end
    endtask

    task automatic test_abort();
        logic [11:0] r;
        logic o;
        int lat, bc;
        int seen;
        run1(8'd137, r, o, lat, bc);
        @(negedge clk);
        bin = 8'd200; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if (busy !== 1'b0 || bcd !== 12'h000 || done !== 1'b0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL abort got busy=%b bcd=%h done=%b want 0/000/0",
                     busy, bcd, done);
        end
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL abort_no_done got=%0d want=0", seen);
        end
        run1(8'd200, r, o, lat, bc);
        checks++;
        if (r !== 12'h200 || o !== 1'b0) begin
            failures++;
            $display("FAIL after_abort got=%h/%b want=200/0", r, o);
        end
    endtask

    task automatic test_clr_start();
        @(negedge clk);
        clr = 1'b1; start = 1'b1; bin = 8'd255;
        @(negedge clk);
        clr = 1'b0; start = 1'b0;
        checks++;
        if ({busy, done, bcd, ovf} !== 15'd0) begin
            failures++;
            $display("FAIL clr_start got=%h want=0", {busy, done, bcd, ovf});
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL clr_start_idle got=%b/%b want=0/0", busy, done);
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_values();
        test_busy_ignore();
        test_back_to_back();
        test_overflow();
        test_abort();
        test_clr_start();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
